// File: rtl/pos_edge_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pos_edge_gen                                                 |
// | Description : Turns single-cycle trigger pulses into clean rising edges on |
// |               a registered level output. Each edge has a programmable high |
// |               time and a guaranteed low (recovery) time. Triggers arriving |
// |               while an edge is in progress are queued up to MAX_PEND.      |
// |               Optional macro POS_EDGE_GEN_EDGE_CNT_EN adds a 16-bit count  |
// |               of emitted rising edges on port edge_cnt.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pos_edge_gen #(
  parameter int CNT_W    = 8,
  parameter int MAX_PEND = 4,
  localparam int PEND_W  = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic              ovf_clr,
  output logic              data,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
`ifdef POS_EDGE_GEN_EDGE_CNT_EN
  , output logic [15:0]     edge_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] C_PEND_FULL = PEND_W'(MAX_PEND);
  localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    hcnt, hcnt_n;
  logic [CNT_W-1:0]    lcnt, lcnt_n;
  logic [PEND_W-1:0]   pend_n;
  logic                ovf_n;
  logic                start;
  logic                have_req;
  logic                drop;
  logic [CNT_W-1:0]    high_len;
  logic [CNT_W-1:0]    low_len;

  // Zero-length phases are promoted to one cycle so every edge is visible.
  assign high_len = (cfg_high == '0) ? C_CNT_ONE : cfg_high;
  assign low_len  = (cfg_low  == '0) ? C_CNT_ONE : cfg_low;
  assign have_req = trig || (pend_cnt != '0);

  // Next-state, phase counters, trigger queue and sticky overflow.
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    lcnt_n  = lcnt;
    start   = 1'b0;
    pend_n  = pend_cnt;
    drop    = 1'b0;
    ovf_n   = ovf;

    case (state)
      ST_IDLE: begin
        if (have_req) start = 1'b1;
      end
      ST_HIGH: begin
        hcnt_n = hcnt - C_CNT_ONE;
        if (hcnt == C_CNT_ONE) begin
          state_n = ST_LOW;
          lcnt_n  = low_len;
        end
      end
      ST_LOW: begin
        lcnt_n = lcnt - C_CNT_ONE;
        if (lcnt == C_CNT_ONE) begin
          if (have_req) start = 1'b1;
          else          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (start) begin
      state_n = ST_HIGH;
      hcnt_n  = high_len;
    end

    // A start prefers a queued trigger; a simultaneous new trigger then
    // takes the freed slot, so the count is unchanged and nothing drops.
    if (start && (pend_cnt != '0)) begin
      if (!trig) pend_n = pend_cnt - PEND_W'(1);
    end else if (!start && trig) begin
      if (pend_cnt == C_PEND_FULL) drop   = 1'b1;
      else                         pend_n = pend_cnt + PEND_W'(1);
    end

    // A new drop takes priority over a clear in the same cycle.
    if (drop)         ovf_n = 1'b1;
    else if (ovf_clr) ovf_n = 1'b0;
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hcnt     <= '0;
      lcnt     <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      data     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      lcnt     <= lcnt_n;
      pend_cnt <= pend_n;
      ovf      <= ovf_n;
      data     <= (state_n == ST_HIGH);
      busy     <= (state_n != ST_IDLE);
    end
  end

`ifdef POS_EDGE_GEN_EDGE_CNT_EN
  // Count of rising edges emitted; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)        edge_cnt <= '0;
    else if (start) edge_cnt <= edge_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pos_edge_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pos_edge_gen                                              |
// | Description : Scoreboard bench for pos_edge_gen. Stimulus pushes the       |
// |               expected rise cycle and high time of each accepted trigger;  |
// |               a monitor pops and checks on every rising edge of data.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pos_edge_gen;
  localparam int CNT_W    = 8;
  localparam int MAX_PEND = 4;
  localparam int PEND_W   = $clog2(MAX_PEND + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              trig;
  logic [CNT_W-1:0]  cfg_high;
  logic [CNT_W-1:0]  cfg_low;
  logic              ovf_clr;
  logic              data;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;
`ifdef POS_EDGE_GEN_EDGE_CNT_EN
  logic [15:0]       edge_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int q_start[$];
  int q_len[$];

  pos_edge_gen #(.CNT_W(CNT_W), .MAX_PEND(MAX_PEND)) dut (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig),
    .cfg_high (cfg_high),
    .cfg_low  (cfg_low),
    .ovf_clr  (ovf_clr),
    .data     (data),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
`ifdef POS_EDGE_GEN_EDGE_CNT_EN
    , .edge_cnt (edge_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_edge(input int start_cyc, input int len);
    q_start.push_back(start_cyc);
    q_len.push_back(len);
  endtask

  // Wait for the generator to drain, bounded.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || pend_cnt != '0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", int'(busy || pend_cnt != '0), 0);
  endtask

  // Monitor: pops the scoreboard on each rising edge and checks high time.
  logic prev_data = 1'b0;
  int   rise_cyc  = 0;
  int   exp_len   = 0;
  always @(negedge clk) begin
    if (rst === 1'b1 || rst === 1'bx) begin
      prev_data = (data === 1'b1);
    end else begin
      if (data && !prev_data) begin
        rise_cyc = cyc;
        if (q_start.size() == 0) begin
          chk("unexpected_edge", cyc, -1);
          exp_len = 0;
        end else begin
          chk("edge_start_cycle", cyc, q_start.pop_front());
          exp_len = q_len.pop_front();
        end
      end else if (!data && prev_data) begin
        chk("edge_high_time", cyc - rise_cyc, exp_len);
      end
      prev_data = data;
    end
  end

  int t0;

  initial begin
    rst = 1'b1; trig = 1'b0; ovf_clr = 1'b0;
    cfg_high = 8'd3; cfg_low = 8'd2;

    // Reset held three cycles with trig toggling.
    for (int i = 0; i < 3; i++) begin
      trig = (i % 2 == 0);
      cycle();
      chk("rst_data", int'(data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pend", int'(pend_cnt), 0);
      chk("rst_ovf",  int'(ovf), 0);
`ifdef POS_EDGE_GEN_EDGE_CNT_EN
      chk("rst_edge_cnt", int'(edge_cnt), 0);
`endif
    end
    rst = 1'b0; trig = 1'b0;
    repeat (6) cycle();
    chk("post_rst_idle", int'(busy), 0);

    // Single edge H=3 L=2.
    t0 = cyc;
    trig = 1'b1; expect_edge(t0 + 1, 3);
    cycle(); trig = 1'b0;
    repeat (4) cycle();                 // now t0+5, last LOW cycle
    chk("single_busy_last", int'(busy), 1);
    cycle();                            // t0+6
    chk("single_busy_done", int'(busy), 0);
    repeat (3) cycle();

    // Zero config: one high cycle, two busy cycles.
    cfg_high = 8'd0; cfg_low = 8'd0;
    t0 = cyc;
    trig = 1'b1; expect_edge(t0 + 1, 1);
    cycle(); trig = 1'b0;
    chk("zero_data_hi", int'(data), 1);
    cycle();
    chk("zero_data_lo", int'(data), 0);
    chk("zero_busy2", int'(busy), 1);
    cycle();
    chk("zero_busy_done", int'(busy), 0);
    repeat (3) cycle();

    // Queue: 4 consecutive trigs, H=2 L=2 -> period 4, peak pend 3.
    cfg_high = 8'd2; cfg_low = 8'd2;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      trig = 1'b1; expect_edge(t0 + 1 + 4 * i, 2);
      cycle();
    end
    trig = 1'b0;                        // now t0+4
    chk("queue_pend_peak", int'(pend_cnt), 3);
    wait_idle(60);
    chk("queue_ovf", int'(ovf), 0);
    repeat (3) cycle();

    // Overflow: 7 trigs during an 8-cycle edge, H=8 L=2 -> period 10.
    cfg_high = 8'd8;
    t0 = cyc;
    for (int i = 0; i < 7; i++) begin
      trig = 1'b1;
      if (i < 5) expect_edge(t0 + 1 + 10 * i, 8);
      cycle();
    end
    trig = 1'b0;                        // now t0+7
    chk("ovf_pend_sat", int'(pend_cnt), 4);
    chk("ovf_set", int'(ovf), 1);
    wait_idle(120);
    chk("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
`ifdef POS_EDGE_GEN_EDGE_CNT_EN
    chk("edge_cnt_total", int'(edge_cnt), 11);
`endif
    repeat (3) cycle();

    // Reset mid-edge with two triggers queued, H=5 L=2.
    cfg_high = 8'd5;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      trig = 1'b1;
      if (i == 0) expect_edge(t0 + 1, 5);
      cycle();
    end
    trig = 1'b0;                        // now t0+3, in HIGH
    chk("midrst_pend", int'(pend_cnt), 2);
    rst = 1'b1; cycle();
    chk("midrst_data", int'(data), 0);
    chk("midrst_pend_clr", int'(pend_cnt), 0);
`ifdef POS_EDGE_GEN_EDGE_CNT_EN
    chk("midrst_edge_cnt", int'(edge_cnt), 0);
`endif
    cycle(); rst = 1'b0;
    repeat (30) cycle();
    chk("midrst_no_edges", int'(busy), 0);
    chk("scoreboard_empty", q_start.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
